// File: rtl/croc_soc_ctrl_if.sv
// Peripheral bus (OBI-style) between a requester and the croc SoC control block.
// Signal names follow the subordinate's point of view.
interface croc_soc_ctrl_if #(
    parameter int unsigned AddrWidth = 32
);
    logic                 req_i;
    logic                 we_i;
    logic [AddrWidth-1:0] addr_i;
    logic [3:0]           be_i;
    logic [31:0]          wdata_i;
    logic                 gnt_o;
    logic                 rvalid_o;
    logic [31:0]          rdata_o;
    logic                 err_o;

    modport master (
        output req_i, we_i, addr_i, be_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, we_i, addr_i, be_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o, err_o
    );
endinterface

// File: rtl/croc_soc_ctrl.sv
// croc SoC control registers: boot address, fetch enable, core status and chip ID.
// Zero-wait subordinate; each granted request is answered exactly one cycle later.
module croc_soc_ctrl #(
    parameter int unsigned AddrWidth       = 32,
    parameter logic [31:0] BootAddrDefault = 32'h1000_0000,
    parameter logic [31:0] IdCode          = 32'h0C0C_5DB3
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    croc_soc_ctrl_if.slave          bus,
    input  logic                    fetch_en_i,
    output logic [31:0]             boot_addr_o,
    output logic                    fetch_en_o,
    output logic                    status_o
);

    typedef enum logic {
        IDLE,
        RESP
    } resp_state_e;

    typedef enum logic [2:0] {
        REG_BOOTADDR   = 3'd0,
        REG_FETCHEN    = 3'd1,
        REG_CORESTATUS = 3'd2,
        REG_IDCODE     = 3'd3
    } reg_sel_e;

    resp_state_e state_q;
    logic [31:0] boot_addr_q, boot_addr_d;
    logic        fetch_en_q, fetch_en_d;
    logic [31:0] core_status_q, core_status_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        status_q;

    logic [2:0]  offset;
    logic        acc_err;
    logic [31:0] be_mask;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.addr_i[AddrWidth-1:5], bus.addr_i[1:0]};

    assign offset  = bus.addr_i[4:2];
    assign acc_err = (offset > REG_IDCODE) || (bus.we_i && (offset == REG_IDCODE));

    always_comb begin
        be_mask = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            be_mask[i*8 +: 8] = {8{bus.be_i[i]}};
        end
    end

    always_comb begin
        boot_addr_d   = boot_addr_q;
        fetch_en_d    = fetch_en_q;
        core_status_d = core_status_q;
        rdata_d       = '0;
        err_d         = bus.req_i && acc_err;
        if (bus.req_i && !acc_err) begin
            if (bus.we_i) begin
                case (offset)
                    REG_BOOTADDR:   boot_addr_d   = (boot_addr_q & ~be_mask) | (bus.wdata_i & be_mask);
                    REG_FETCHEN:    if (bus.be_i[0]) fetch_en_d = bus.wdata_i[0];
                    REG_CORESTATUS: core_status_d = (core_status_q & ~be_mask) | (bus.wdata_i & be_mask);
                    default:        ;
                endcase
            end else begin
                case (offset)
                    REG_BOOTADDR:   rdata_d = boot_addr_q;
                    REG_FETCHEN:    rdata_d = {31'd0, fetch_en_q};
                    REG_CORESTATUS: rdata_d = core_status_q;
                    REG_IDCODE:     rdata_d = IdCode;
                    default:        rdata_d = '0;
                endcase
            end
        end
    end

    // status follows the next CORESTATUS value so the pin moves in the response cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            boot_addr_q   <= BootAddrDefault;
            fetch_en_q    <= 1'b0;
            core_status_q <= '0;
            rdata_q       <= '0;
            err_q         <= 1'b0;
            status_q      <= 1'b0;
        end else begin
            state_q       <= bus.req_i ? RESP : IDLE;
            boot_addr_q   <= boot_addr_d;
            fetch_en_q    <= fetch_en_d;
            core_status_q <= core_status_d;
            rdata_q       <= rdata_d;
            err_q         <= err_d;
            status_q      <= (core_status_d != '0);
        end
    end

    assign bus.gnt_o    = bus.req_i;
    assign bus.rvalid_o = (state_q == RESP);
    assign bus.rdata_o  = rdata_q;
    assign bus.err_o    = err_q;

    assign boot_addr_o = boot_addr_q;
    assign fetch_en_o  = fetch_en_i | fetch_en_q;
    assign status_o    = status_q;

endmodule

// File: tb/tb_croc_soc_ctrl.sv
// Directed-vector bench for croc_soc_ctrl with hand-computed expectations.
module tb_croc_soc_ctrl;

    localparam logic [31:0] BOOT_DEF = 32'h1000_0000;
    localparam logic [31:0] ID_CODE  = 32'h0C0C_5DB3;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        fetch_en_i = 1'b0;
    logic [31:0] boot_addr_o;
    logic        fetch_en_o;
    logic        status_o;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    croc_soc_ctrl_if #(.AddrWidth(32)) bus ();

    croc_soc_ctrl #(
        .AddrWidth      (32),
        .BootAddrDefault(BOOT_DEF),
        .IdCode         (ID_CODE)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .bus        (bus),
        .fetch_en_i (fetch_en_i),
        .boot_addr_o(boot_addr_o),
        .fetch_en_o (fetch_en_o),
        .status_o   (status_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wdata);
        bus.req_i   = 1'b1;
        bus.we_i    = we;
        bus.addr_i  = addr;
        bus.be_i    = be;
        bus.wdata_i = wdata;
    endtask

    task automatic idle_bus();
        bus.req_i   = 1'b0;
        bus.we_i    = 1'b0;
        bus.addr_i  = '0;
        bus.be_i    = '0;
        bus.wdata_i = '0;
    endtask

    // One isolated transaction: request for one cycle, check the response, then one idle cycle.
    task automatic xfer(input string tag, input logic we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err);
        @(negedge clk_i);
        drive(we, addr, be, wdata);
        #1;
        check({tag, ".gnt"}, {31'd0, bus.gnt_o}, 32'd1);
        @(posedge clk_i);
        #1;
        idle_bus();
        check({tag, ".rvalid"}, {31'd0, bus.rvalid_o}, 32'd1);
        check({tag, ".rdata"}, bus.rdata_o, exp_rdata);
        check({tag, ".err"}, {31'd0, bus.err_o}, {31'd0, exp_err});
        @(posedge clk_i);
        #1;
        check({tag, ".rvalid_drop"}, {31'd0, bus.rvalid_o}, 32'd0);
    endtask

    initial begin
        idle_bus();
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        check("rst.rvalid", {31'd0, bus.rvalid_o}, 32'd0);
        check("rst.rdata", bus.rdata_o, 32'd0);
        check("rst.err", {31'd0, bus.err_o}, 32'd0);
        check("rst.status", {31'd0, status_o}, 32'd0);
        check("rst.fetch_en", {31'd0, fetch_en_o}, 32'd0);
        check("rst.boot_addr", boot_addr_o, BOOT_DEF);

        // reset values via bus
        xfer("rd_boot", 1'b0, 32'h00, 4'h0, 32'h0, 32'h1000_0000, 1'b0);
        xfer("rd_fen", 1'b0, 32'h04, 4'h0, 32'h0, 32'h0, 1'b0);
        xfer("rd_cs", 1'b0, 32'h08, 4'h0, 32'h0, 32'h0, 1'b0);
        xfer("rd_id", 1'b0, 32'h0C, 4'h0, 32'h0, 32'h0C0C_5DB3, 1'b0);

        // boot address, full and partial byte enables
        xfer("wr_boot", 1'b1, 32'h00, 4'hF, 32'h1000_0080, 32'h0, 1'b0);
        check("boot_addr_o", boot_addr_o, 32'h1000_0080);
        xfer("rd_boot2", 1'b0, 32'h00, 4'h0, 32'h0, 32'h1000_0080, 1'b0);
        xfer("wr_boot_b0", 1'b1, 32'h00, 4'h1, 32'hFFFF_FFAA, 32'h0, 1'b0);
        xfer("rd_boot3", 1'b0, 32'h00, 4'h0, 32'h0, 32'h1000_00AA, 1'b0);
        xfer("wr_boot_be0", 1'b1, 32'h00, 4'h0, 32'h1234_5678, 32'h0, 1'b0);
        xfer("rd_boot4", 1'b0, 32'h00, 4'h0, 32'h0, 32'h1000_00AA, 1'b0);

        // fetch enable
        fetch_en_i = 1'b1;
        #1;
        check("fen_pin", {31'd0, fetch_en_o}, 32'd1);
        fetch_en_i = 1'b0;
        #1;
        check("fen_pin_off", {31'd0, fetch_en_o}, 32'd0);
        xfer("wr_fen1", 1'b1, 32'h04, 4'hF, 32'h1, 32'h0, 1'b0);
        check("fen_reg", {31'd0, fetch_en_o}, 32'd1);
        xfer("wr_fen0", 1'b1, 32'h04, 4'hF, 32'h0, 32'h0, 1'b0);
        check("fen_reg_off", {31'd0, fetch_en_o}, 32'd0);
        xfer("wr_fen_all", 1'b1, 32'h04, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b0);
        xfer("rd_fen_all", 1'b0, 32'h04, 4'h0, 32'h0, 32'h1, 1'b0);
        xfer("wr_fen_be0", 1'b1, 32'h04, 4'h0, 32'h0, 32'h0, 1'b0);
        xfer("rd_fen_be0", 1'b0, 32'h04, 4'h0, 32'h0, 32'h1, 1'b0);

        // core status
        @(negedge clk_i);
        drive(1'b1, 32'h08, 4'hF, 32'h1);
        #1;
        check("status_pre", {31'd0, status_o}, 32'd0);
        @(posedge clk_i);
        #1;
        idle_bus();
        check("status_rise", {31'd0, status_o}, 32'd1);
        check("wr_cs.rvalid", {31'd0, bus.rvalid_o}, 32'd1);
        xfer("rd_cs1", 1'b0, 32'h08, 4'h0, 32'h0, 32'h1, 1'b0);
        xfer("wr_cs0", 1'b1, 32'h08, 4'hF, 32'h0, 32'h0, 1'b0);
        check("status_fall", {31'd0, status_o}, 32'd0);

        // error accesses and ignored address bits
        xfer("wr_id", 1'b1, 32'h0C, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b1);
        xfer("rd_0x14", 1'b0, 32'h14, 4'h0, 32'h0, 32'h0, 1'b1);
        xfer("wr_0x1C", 1'b1, 32'h1C, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b1);
        xfer("rd_id2", 1'b0, 32'h0C, 4'h0, 32'h0, 32'h0C0C_5DB3, 1'b0);
        xfer("rd_hi_addr", 1'b0, 32'h0000_0100, 4'h0, 32'h0, 32'h1000_00AA, 1'b0);
        xfer("rd_unalign", 1'b0, 32'h0B, 4'h0, 32'h0, 32'h0, 1'b0);
        check("err_no_state", boot_addr_o, 32'h1000_00AA);

        // back-to-back write then read, then reset mid-stream
        @(negedge clk_i);
        drive(1'b1, 32'h08, 4'hF, 32'h5);
        @(posedge clk_i);
        #1;
        check("b2b_wr.rvalid", {31'd0, bus.rvalid_o}, 32'd1);
        check("b2b_wr.rdata", bus.rdata_o, 32'd0);
        drive(1'b0, 32'h08, 4'h0, 32'h0);
        @(posedge clk_i);
        #1;
        check("b2b_rd.rvalid", {31'd0, bus.rvalid_o}, 32'd1);
        check("b2b_rd.rdata", bus.rdata_o, 32'h5);
        check("b2b_status", {31'd0, status_o}, 32'd1);
        drive(1'b0, 32'h00, 4'h0, 32'h0);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        idle_bus();
        check("mid_rst.rvalid", {31'd0, bus.rvalid_o}, 32'd0);
        check("mid_rst.rdata", bus.rdata_o, 32'd0);
        check("mid_rst.status", {31'd0, status_o}, 32'd0);
        check("mid_rst.boot", boot_addr_o, BOOT_DEF);
        xfer("rd_cs_rst", 1'b0, 32'h08, 4'h0, 32'h0, 32'h0, 1'b0);
        xfer("rd_fen_rst", 1'b0, 32'h04, 4'h0, 32'h0, 32'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
